// File: rtl/axis_fx3_slave_fifo_wr_if.sv
// Purpose: bundles the AXI-Stream sink side and the FX3 slave-FIFO write pins of the FX3 writer.
// Latency: none; this is wiring only.
// Backpressure: s_axis_tready is driven by the writer and flows back to the stream source.
interface axis_fx3_slave_fifo_wr_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] fx3_dq;
  logic [1:0]            fx3_addr;
  logic                  fx3_slcs_n;
  logic                  fx3_slwr_n;
  logic                  fx3_pktend_n;
  logic                  fx3_sloe_n;
  logic                  fx3_slrd_n;
  logic                  fx3_flaga;
  logic                  fx3_flagb;

  // Writer side: consumes the stream and the FX3 flags, drives the FX3 pins.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fx3_flaga, fx3_flagb,
    output s_axis_tready, fx3_dq, fx3_addr, fx3_slcs_n, fx3_slwr_n,
           fx3_pktend_n, fx3_sloe_n, fx3_slrd_n
  );

  // Environment side: stream source plus the FX3 device model.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fx3_flaga, fx3_flagb,
    input  s_axis_tready, fx3_dq, fx3_addr, fx3_slcs_n, fx3_slwr_n,
           fx3_pktend_n, fx3_sloe_n, fx3_slrd_n
  );
endinterface

// File: rtl/axis_fx3_slave_fifo_wr.sv
// Purpose: drains an AXI-Stream into the FX3 GPIF-II slave FIFO, one DMA buffer of BURST_LEN words at a time.
// Latency: an accepted beat appears on fx3_dq with fx3_slwr_n low exactly one cycle later.
// Backpressure: tready drops while flagb signals the watermark, and during IDLE/COOLDOWN.
module axis_fx3_slave_fifo_wr #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         BURST_LEN    = 1024,
  parameter int         FLAG_LATENCY = 3,
  parameter logic [1:0] THREAD_ADDR  = 2'b00
) (
  input  logic                         aclk,
  input  logic                         areset,
  axis_fx3_slave_fifo_wr_if.slave      bus,
  output logic                         busy,
  output logic [15:0]                  pkt_cnt
);

  typedef enum logic [1:0] {IDLE, BURST, COOLDOWN} state_t;

  localparam logic [15:0] BLEN     = 16'(BURST_LEN);
  localparam logic [3:0]  LAT_LAST = 4'(FLAG_LATENCY - 1);

  state_t                state_q, state_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [3:0]            lat_q, lat_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d;
  logic                  slwr_n_q, slwr_n_d;
  logic                  pktend_n_q, pktend_n_d;
  logic                  slcs_n_q, slcs_n_d;
  logic                  tready;
  logic                  accept;
  logic [15:0]           wcnt_inc;

  // Ready never looks at tvalid; wcnt<BLEN is a guard, the FSM leaves BURST once the buffer fills.
  assign tready   = (state_q == BURST) && bus.fx3_flagb && (wcnt_q < BLEN);
  assign accept   = bus.s_axis_tvalid && tready;
  assign wcnt_inc = wcnt_q + 16'd1;

  // Next-state and registered-output decode; a full buffer wins over tlast so no pktend is sent.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    lat_d      = lat_q;
    pkt_cnt_d  = pkt_cnt_q;
    dq_d       = dq_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.fx3_flaga && bus.s_axis_tvalid) state_d = BURST;
      end
      BURST: begin
        if (accept) begin
          wcnt_d   = wcnt_inc;
          dq_d     = bus.s_axis_tdata;
          slwr_n_d = 1'b0;
          if (wcnt_inc == BLEN) begin
            state_d = COOLDOWN;
          end else if (bus.s_axis_tlast) begin
            pktend_n_d = 1'b0;
            state_d    = COOLDOWN;
          end
          if (state_d == COOLDOWN) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            lat_d     = 4'd0;
          end
        end
      end
      COOLDOWN: begin
        if (lat_q == LAT_LAST) begin
          wcnt_d  = 16'd0;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered from the next state so chip select lines up with the state it belongs to.
    slcs_n_d = (state_d == IDLE);
  end

  // State and FX3 pin registers; reset drops any partially written buffer without a commit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      lat_q      <= '0;
      pkt_cnt_q  <= '0;
      dq_q       <= '0;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      slcs_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      lat_q      <= lat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      dq_q       <= dq_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      slcs_n_q   <= slcs_n_d;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.fx3_dq        = dq_q;
  assign bus.fx3_addr      = THREAD_ADDR;
  assign bus.fx3_slcs_n    = slcs_n_q;
  assign bus.fx3_slwr_n    = slwr_n_q;
  assign bus.fx3_pktend_n  = pktend_n_q;
  assign bus.fx3_sloe_n    = 1'b1;
  assign bus.fx3_slrd_n    = 1'b1;
  assign busy              = (state_q != IDLE);
  assign pkt_cnt           = pkt_cnt_q;

endmodule

// File: tb/tb_axis_fx3_slave_fifo_wr.sv
// Purpose: exercises the FX3 writer with directed and random streams against a buffer-level reference model.
// Latency: expects each accepted beat on the FX3 bus one cycle later, commits gapped by FLAG_LATENCY+2.
// Backpressure: toggles flaga/flagb and tvalid gaps; the source holds tvalid until a beat is taken.
module tb_axis_fx3_slave_fifo_wr;

  localparam int DW = 32;
  localparam int BL = 8;
  localparam int FL = 3;

  typedef struct { logic [31:0] d; logic last; } beat_t;
  typedef struct { logic [31:0] d; logic pe; logic commit; } word_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        busy;
  logic [15:0] pkt_cnt;

  axis_fx3_slave_fifo_wr_if #(.DATA_WIDTH(DW)) bus ();

  axis_fx3_slave_fifo_wr #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .FLAG_LATENCY(FL), .THREAD_ADDR(2'b10)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus.slave), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 aclk = ~aclk;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t beats[$];
  word_t exp_q[$];
  int    buf_fill = 0;     // words in the currently open FX3 buffer (model)
  int    commits  = 0;     // buffers the model expects committed since reset
  int    accepted = 0;
  int    cyc      = 0;
  int    last_commit_cyc = 0;
  bit    gap_pending = 0;
  bit    exact_gap   = 0;
  bit    mon_en      = 0;
  bit    rand_flags  = 0;
  int    gap_pct     = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference: every beat becomes one FX3 word; a buffer closes when full (no pktend)
  // or when tlast arrives first (pktend on that word).
  task automatic push_packet(input int len, input bit rnd, input logic [31:0] base);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      word_t w;
      b.d = rnd ? $urandom() : base + 32'(i);
      b.last = (i == len - 1);
      beats.push_back(b);
      buf_fill++;
      w.d = b.d;
      w.pe = 1'b0;
      w.commit = 1'b0;
      if (buf_fill == BL) begin
        w.commit = 1'b1;
        buf_fill = 0;
      end else if (b.last) begin
        w.commit = 1'b1;
        w.pe = 1'b1;
        buf_fill = 0;
      end
      exp_q.push_back(w);
    end
  endtask

  // One clock of the stream source and FX3 flag model.
  task automatic step();
    bit fire;
    @(negedge aclk);
    fire = bus.s_axis_tvalid && bus.s_axis_tready;
    @(posedge aclk);
    #1;
    if (fire) begin
      void'(beats.pop_front());
      accepted++;
    end
    if (!(bus.s_axis_tvalid && !fire)) begin
      if (beats.size() > 0 && $urandom_range(99) >= gap_pct) begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = beats[0].d;
        bus.s_axis_tlast  = beats[0].last;
      end else begin
        bus.s_axis_tvalid = 1'b0;
      end
    end
    if (rand_flags) begin
      bus.fx3_flaga = ($urandom_range(99) >= 30);
      bus.fx3_flagb = ($urandom_range(99) >= 15);
    end
  endtask

  task automatic drain();
    int budget = 3000;
    while ((exp_q.size() != 0 || beats.size() != 0 || busy) && budget > 0) begin
      step();
      budget--;
    end
    check_val("drain_done", 32'(budget > 0), 32'd1);
  endtask

  task automatic wait_accepts(input int target);
    int budget = 500;
    while (accepted < target && budget > 0) begin
      step();
      budget--;
    end
    check_val("accept_wait", 32'(accepted >= target), 32'd1);
  endtask

  // FX3-side scoreboard: data order, pktend placement, commit count and post-commit gap.
  always @(negedge aclk) begin
    cyc++;
    if (mon_en) begin
      check_val("tready_while_flagb_low", 32'(bus.s_axis_tready & ~bus.fx3_flagb), 32'd0);
      if (!bus.fx3_slwr_n) begin
        check_val("slcs_during_write", 32'(bus.fx3_slcs_n), 32'd0);
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check_val("dq", bus.fx3_dq, w.d);
          check_val("pktend_n", 32'(bus.fx3_pktend_n), 32'(!w.pe));
          if (gap_pending) begin
            if (exact_gap) check_val("commit_gap_exact", 32'(cyc - last_commit_cyc), 32'(FL + 2));
            else check_val("commit_gap_min", 32'(cyc - last_commit_cyc >= FL + 2), 32'd1);
            gap_pending = 0;
          end
          if (w.commit) begin
            commits++;
            last_commit_cyc = cyc;
            gap_pending = 1;
          end
        end
      end else begin
        check_val("pktend_without_write", 32'(bus.fx3_pktend_n), 32'd1);
      end
      if (!areset) check_val("pkt_cnt", 32'(pkt_cnt), 32'(commits & 16'hFFFF));
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded time bound, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    areset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.fx3_flaga = 1'b1;
    bus.fx3_flagb = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_val("rst_slcs_n", 32'(bus.fx3_slcs_n), 32'd1);
    check_val("rst_slwr_n", 32'(bus.fx3_slwr_n), 32'd1);
    check_val("rst_pktend_n", 32'(bus.fx3_pktend_n), 32'd1);
    check_val("rst_sloe_n", 32'(bus.fx3_sloe_n), 32'd1);
    check_val("rst_slrd_n", 32'(bus.fx3_slrd_n), 32'd1);
    check_val("rst_dq", bus.fx3_dq, 32'd0);
    check_val("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check_val("rst_addr", 32'(bus.fx3_addr), 32'd2);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    mon_en = 1;

    // Full buffer 1..8, short packet A,B,C, then a 20-beat packet split 8/8/4.
    exact_gap = 1;
    push_packet(8, 0, 32'h1);
    push_packet(3, 0, 32'hA);
    push_packet(20, 0, 32'h100);
    drain();
    check_val("pkt_cnt_after_directed", 32'(pkt_cnt), 32'd5);
    exact_gap = 0;

    // flaga low holds the writer in IDLE even with data waiting.
    bus.fx3_flaga = 1'b0;
    push_packet(2, 1, 0);
    repeat (4) begin
      step();
      check_val("noflaga_slcs_n", 32'(bus.fx3_slcs_n), 32'd1);
      check_val("noflaga_tready", 32'(bus.s_axis_tready), 32'd0);
      check_val("noflaga_busy", 32'(busy), 32'd0);
    end
    bus.fx3_flaga = 1'b1;
    step();
    check_val("flaga_to_burst", 32'(busy), 32'd1);
    step();
    check_val("first_write_2cyc", 32'(bus.fx3_slwr_n), 32'd0);
    drain();

    // Watermark pause after word 3 of an 8-word buffer.
    base = accepted;
    push_packet(8, 1, 0);
    wait_accepts(base + 3);
    bus.fx3_flagb = 1'b0;
    repeat (5) begin
      step();
      check_val("pause_tready", 32'(bus.s_axis_tready), 32'd0);
      check_val("pause_slwr_n", 32'(bus.fx3_slwr_n), 32'd1);
      check_val("pause_busy", 32'(busy), 32'd1);
    end
    bus.fx3_flagb = 1'b1;
    drain();

    // Reset after word 5 of 8: the open buffer is abandoned, nothing is committed.
    base = accepted;
    push_packet(8, 1, 0);
    wait_accepts(base + 5);
    areset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    beats.delete();
    repeat (3) void'(exp_q.pop_back());
    buf_fill = 0;
    step();
    areset = 1'b0;
    commits = 0;
    gap_pending = 0;
    check_val("midrst_slwr_n", 32'(bus.fx3_slwr_n), 32'd1);
    check_val("midrst_pktend_n", 32'(bus.fx3_pktend_n), 32'd1);
    check_val("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_exp_left", 32'(exp_q.size()), 32'd0);
    push_packet(5, 1, 0);
    drain();
    check_val("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Random packets with tvalid gaps and flag noise.
    rand_flags = 1;
    gap_pct = 30;
    for (int p = 0; p < 30; p++) push_packet($urandom_range(20, 1), 1, 0);
    drain();
    rand_flags = 0;
    bus.fx3_flaga = 1'b1;
    bus.fx3_flagb = 1'b1;
    repeat (FL + 3) step();
    check_val("end_busy", 32'(busy), 32'd0);
    check_val("end_sloe_n", 32'(bus.fx3_sloe_n), 32'd1);
    check_val("end_slrd_n", 32'(bus.fx3_slrd_n), 32'd1);
    check_val("end_addr", 32'(bus.fx3_addr), 32'd2);
    check_val("end_pkt_cnt", 32'(pkt_cnt), 32'(commits & 16'hFFFF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
